// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: symbolic request in, encoded words out.
// The master drives requests and pops words; the slave is the encoder.
interface instr_encoder_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          req_valid;
   logic          req_ready;
   logic [4:0]    req_op;
   logic [4:0]    req_rs;
   logic [4:0]    req_rt;
   logic [4:0]    req_rd;
   logic [4:0]    req_shamt;
   logic [31:0]   req_imm;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [CW-1:0] out_count;
   logic          err;

   modport master (
      output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, out_ready,
      input  req_ready, out_valid, out_instr, out_count, err
   );

   modport slave (
      input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, out_ready,
      output req_ready, out_valid, out_instr, out_count, err
   );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder feeding a first-word-fall-through FIFO.
// Define INSTR_ENCODER_PSEUDO_EN to enable the LI pseudo-op (two-word expansion via LI_LO).
module instr_encoder #(
   parameter int FIFO_DEPTH = 4
) (
   input logic           clk,
   input logic           reset,
   instr_encoder_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_LI_LO = 1'b1} state_t;

   typedef struct packed {
      logic        ok;
      logic        two;
      logic [31:0] word;
   } enc_t;

   function automatic enc_t f_encode(input logic [4:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [31:0] imm);
      enc_t e;
      e = '0;
      e.ok = 1'b1;
      case (op)
         5'd0:  e.word = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
         5'd1:  e.word = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
         5'd2:  e.word = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
         5'd3:  e.word = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
         5'd4:  e.word = {6'b000000, rs, rt, rd, 5'd0, 6'b100110};
         5'd5:  e.word = {6'b000000, rs, rt, rd, 5'd0, 6'b100111};
         5'd6:  e.word = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
         5'd7:  e.word = {6'b000000, rs, rt, rd, 5'd0, 6'b101011};
         5'd8:  e.word = {6'b000000, 5'd0, rt, rd, sh, 6'b000000};
         5'd9:  e.word = {6'b000000, 5'd0, rt, rd, sh, 6'b000010};
         5'd10: e.word = {6'b000000, 5'd0, rt, rd, sh, 6'b000011};
         5'd11: e.word = {6'b000000, rs, 15'd0, 6'b001000};
         5'd12: e.word = {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001001};
         5'd13: e.word = {6'b001001, rs, rt, imm[15:0]};
         5'd14: e.word = {6'b001101, rs, rt, imm[15:0]};
         5'd15: e.word = {6'b001111, 5'd0, rt, imm[15:0]};
         5'd16: e.word = {6'b100011, rs, rt, imm[15:0]};
         5'd17: e.word = {6'b101011, rs, rt, imm[15:0]};
         5'd18: e.word = {6'b000100, rs, rt, imm[15:0]};
         5'd19: e.word = {6'b000101, rs, rt, imm[15:0]};
         5'd20: e.word = {6'b000011, imm[25:0]};
         5'd21: e.word = {6'b010000, 5'b00000, rt, rd, 11'd0};
         5'd22: e.word = {6'b010000, 5'b00100, rt, rd, 11'd0};
         5'd23: e.word = 32'h4200_0018;
         5'd24: begin
            // Short forms: ORI when the upper half is zero, LUI alone when the lower half is zero.
            e.word = (imm[31:16] == 16'd0) ? {6'b001101, 5'd0, rt, imm[15:0]}
                                           : {6'b001111, 5'd0, rt, imm[31:16]};
            e.two  = (imm[31:16] != 16'd0) && (imm[15:0] != 16'd0);
`ifdef INSTR_ENCODER_PSEUDO_EN
            e.ok   = 1'b1;
`else
            e.ok   = 1'b0;
`endif
         end
         5'd25:   e.word = 32'h0000_0000;
         default: e.ok = 1'b0;
      endcase
      return e;
   endfunction

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic          r_err;
   logic [4:0]    r_li_rt;
   logic [15:0]   r_li_imm;
   logic [31:0]   r_mem [FIFO_DEPTH];

   enc_t          w_enc;
   logic          w_full;
   logic          w_valid;
   logic          w_li_lo;
   logic          w_req_ready;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_push_word;

   always_comb begin
      w_enc       = f_encode(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd,
                             bus.req_shamt, bus.req_imm);
      w_full      = (r_count == CW'(FIFO_DEPTH));
      w_valid     = (r_count != {CW{1'b0}});
      w_li_lo     = (r_state == S_LI_LO);
      w_req_ready = !w_li_lo && !w_full;
      w_accept    = bus.req_valid && w_req_ready;
      w_pop       = w_valid && bus.out_ready;
      if (w_li_lo) begin
         w_push      = !w_full;
         w_push_word = {6'b001101, r_li_rt, r_li_rt, r_li_imm};
      end else begin
         w_push      = w_accept && w_enc.ok;
         w_push_word = w_enc.word;
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.out_valid = w_valid;
   assign bus.out_instr = w_valid ? r_mem[r_rd_ptr] : 32'h0000_0000;
   assign bus.out_count = r_count;
   assign bus.err       = r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_count  <= {CW{1'b0}};
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_err    <= 1'b0;
         r_li_rt  <= 5'd0;
         r_li_imm <= 16'd0;
      end else begin
         r_err   <= w_accept && !w_enc.ok;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_enc.ok && w_enc.two) begin
                  r_state  <= S_LI_LO;
                  r_li_rt  <= bus.req_rt;
                  r_li_imm <= bus.req_imm[15:0];
               end
            end
            S_LI_LO: begin
               if (!w_full) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Storage needs no reset: the count gates visibility of every entry.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_word;
   end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder: accepts symbolic operation requests (op code plus register, shift and immediate fields) over a valid/ready handshake and emits encoded 32-bit instruction words into a small first-word-fall-through FIFO. It is the inverse of the pipeline's instruction classifier and sits in the test and boot infrastructure, feeding IM preload logic or a bench driver. It expands the `LI` pseudo-op into one or two real instructions through a two-state FSM.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of two and at least 2.
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_op` in 5: operation select (see Operation).
- `req_rs`, `req_rt`, `req_rd`, `req_shamt` in 5 each: register and shift fields.
- `req_imm` in 32: immediate. Uses [15:0] for I-type and branch, [25:0] for JAL, and all 32 bits for LI.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer pops the head when `out_valid && out_ready`.
- `out_instr` out 32: FIFO head; forced to 32'h0 when `out_valid`=0.
- `out_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `err` out 1: one-cycle pulse when an accepted request carries an invalid op.

## Operation
- **Op codes:**
  - 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA, 11 JR, 12 JALR
  - 13 ADDIU, 14 ORI, 15 LUI, 16 LW, 17 SW, 18 BEQ, 19 BNE
  - 20 JAL, 21 MFC0, 22 MTC0, 23 ERET, 24 LI, 25 NOP
  - 26–31 invalid.
- **R-type** (opcode 000000), fields rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]:
  - Funct values: ADDU 100001, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011.
  - Non-shift ops force shamt=0.
  - Shift ops force rs=0.
  - JR: rs only, funct 001000.
  - JALR: rs and rd, funct 001001.
- **I-type:** opcode, rs, rt, imm[15:0]. Opcodes: ADDIU 001001, ORI 001101, LUI 001111 (rs forced 0), LW 100011, SW 101011, BEQ 000100, BNE 000101.
- **JAL:** 000011, imm[25:0].
- **Coprocessor 0:**
  - MFC0 = {010000, 00000, rt, rd, 11'b0}.
  - MTC0 = {010000, 00100, rt, rd, 11'b0}.
  - ERET = 32'h42000018.
- **NOP:** 32'h0.
- **LI** (target register rt):
  - imm[31:16]==0: single `ORI rt,$0,imm[15:0]`.
  - Otherwise, imm[15:0]==0: single `LUI rt,imm[31:16]`.
  - Otherwise: `LUI rt,imm[31:16]` followed by `ORI rt,rt,imm[15:0]`.
- **FSM states:**
  - IDLE: `req_ready = (out_count != FIFO_DEPTH)`.
    - Accepted two-word LI pushes the LUI word, latches rt and imm[15:0], and moves to LI_LO.
    - Every other accepted request pushes 0 or 1 words and stays in IDLE.
  - LI_LO: `req_ready`=0. When the FIFO is not full, pushes the ORI word and returns to IDLE.
- **Invalid op:** request is accepted (consumed), nothing is pushed, and `err`=1 for exactly the following cycle.
- **FIFO:**
  - Push and pop in the same cycle update the count by net zero.
  - Fullness for push is judged on the pre-pop count, so a full FIFO with a simultaneous pop still refuses the push.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop with `out_valid`=0 is ignored.

## Timing
- Accepted request to word visible on `out_instr`: 1 cycle when the FIFO was empty.
- Two-word LI: LUI visible 1 cycle after acceptance; ORI enqueued no earlier than the next cycle, and later if the FIFO is full.
- Throughput: one request per cycle in IDLE while the FIFO is not full.
- Values during and immediately after reset:
  - FSM state IDLE.
  - `out_count`=0, `out_valid`=0, `out_instr`=0, `err`=0, `req_ready`=1.
  - Requests presented while `reset` is high are ignored.
- Reset asserted in LI_LO: FIFO contents and the pending ORI are discarded.

## Configuration
- `INSTR_ENCODER_PSEUDO_EN` defined: LI (op 24) and the LI_LO state are compiled in.
- `INSTR_ENCODER_PSEUDO_EN` undefined:
  - Op 24 is invalid (pulses `err`, pushes nothing).
  - The FSM reduces to IDLE only and `req_ready` depends solely on FIFO fullness.

## Test plan
- ADDU rs=1 rt=2 rd=3 with `out_ready`=1 -> `out_instr`=0x00221821 with `out_valid`=1 one cycle later, then FIFO empty.
- LI rt=8 imm=0x12345678 -> 0x3C081234 followed by 0x35085678; `req_ready`=0 for the LI_LO cycle. LI rt=8 imm=0x0000BEEF -> single 0x3408BEEF.
- MTC0 rt=5 rd=12 -> 0x40856000; ERET -> 0x42000018; JAL imm=0x0000040 -> 0x0C000040.
- `out_ready`=0, FIFO_DEPTH=4, five back-to-back NOPs -> four accepted, `out_count`=4, `req_ready`=0, fifth held. A pop with a simultaneous request must not accept that request in the same cycle.
- Op 31 -> `err` high exactly one cycle, `out_count` unchanged, `req_ready` stays 1.
- LI imm=0x12345678 with FIFO_DEPTH-1 entries queued and `out_ready`=0 -> FSM waits in LI_LO. Assert `reset` -> `out_count`=0, `out_valid`=0, and no ORI is ever emitted after release.
